// File: rtl/actuator_arbiter.sv
// Six-way actuator arbiter: fixed priority with round-robin doors, minimum
// hold time per grant and a mandatory dead gap between grants.
module actuator_arbiter #(
  parameter int HOLD_CYC = 8,
  parameter int DEAD_CYC = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] req,
  output logic [5:0] gnt,
  output logic [2:0] owner,
  output logic       busy,
  output logic       conflict,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DEAD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [2:0]       NO_OWNER  = 3'd7;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       gnt_q, gnt_d;
  logic [2:0]       owner_q, owner_d;
  // rr_q high means rdoor held the most recent door grant, so fdoor wins the next tie
  logic             rr_q, rr_d;

  logic [5:0] eligible;
  logic       win_valid;
  logic [2:0] win_idx;
  logic       owner_req;
  logic       hold_done;
  logic       preempt;
  logic       thermal_kill;

  // Handshake: req is level-sensitive and never latched; a request is honoured
  // only if it is high at the IDLE edge, and gnt answers from the next cycle on.
  assign conflict  = req[4] & req[5];
  assign eligible  = conflict ? (req & 6'b001111) : req;
  assign win_valid = |eligible;

  always_comb begin
    win_idx = NO_OWNER;
    if (eligible[3])                     win_idx = 3'd3;
    else if (eligible[0] && eligible[1]) win_idx = rr_q ? 3'd0 : 3'd1;
    else if (eligible[0])                win_idx = 3'd0;
    else if (eligible[1])                win_idx = 3'd1;
    else if (eligible[2])                win_idx = 3'd2;
    else if (eligible[4])                win_idx = 3'd4;
    else if (eligible[5])                win_idx = 3'd5;
  end

  assign owner_req    = |(req & gnt_q);
  assign hold_done    = (cnt_q == HOLD_LAST);
  assign preempt      = req[3] && (owner_q != 3'd3);
  assign thermal_kill = conflict && ((owner_q == 3'd4) || (owner_q == 3'd5));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = GRANT;
          cnt_d   = '0;
          gnt_d   = 6'(1) << win_idx;
          owner_d = win_idx;
          if (win_idx == 3'd0) rr_d = 1'b0;
          if (win_idx == 3'd1) rr_d = 1'b1;
        end
      end
      GRANT: begin
        if (!hold_done) cnt_d = cnt_q + 1'b1;
        if (preempt || thermal_kill || (hold_done && !owner_req)) begin
          state_d = DEAD;
          cnt_d   = '0;
          gnt_d   = '0;
          owner_d = NO_OWNER;
        end
      end
      DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        gnt_d   = '0;
        owner_d = NO_OWNER;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      owner_q <= NO_OWNER;
      rr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_actuator_arbiter.sv
// Bench for actuator_arbiter: directed scenarios plus randomized traffic,
// all checked against a grant/gap timeline model.
module tb_actuator_arbiter;

  localparam int HOLD = 8;
  localparam int DEAD = 4;

  logic       clk;
  logic       rst_n;
  logic [5:0] req;
  logic [5:0] gnt;
  logic [2:0] owner;
  logic       busy;
  logic       conflict;
  logic [1:0] dbg_state;

  int checks;
  int errors;

  actuator_arbiter #(.HOLD_CYC(HOLD), .DEAD_CYC(DEAD), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .owner(owner),
    .busy(busy), .conflict(conflict), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who owns the actuators, how long they have held, how many zero
  // cycles have elapsed since the last grant ended, and which door went last.
  int m_owner;
  int m_held;
  int m_zero;
  int m_last_door;

  function automatic void model_reset();
    m_owner     = -1;
    m_held      = 0;
    m_zero      = 1000;
    m_last_door = 1;
  endfunction

  function automatic int pick(input logic [5:0] r);
    logic [5:0] e;
    e = r;
    if (e[4] && e[5]) e[5:4] = 2'b00;
    if (e[3]) return 3;
    if (e[0] && e[1]) return (m_last_door == 0) ? 1 : 0;
    if (e[0]) return 0;
    if (e[1]) return 1;
    if (e[2]) return 2;
    if (e[4]) return 4;
    if (e[5]) return 5;
    return -1;
  endfunction

  function automatic void model_step(input logic [5:0] r);
    int w;
    if (m_owner >= 0) begin
      m_held++;
      if ((r[3] && m_owner != 3) || (m_owner >= 4 && r[4] && r[5]) ||
          (m_held >= HOLD && !r[m_owner])) begin
        m_owner = -1;
        m_zero  = 0;
      end
    end else begin
      if (m_zero < 1000) m_zero++;
      if (m_zero > DEAD) begin
        w = pick(r);
        if (w >= 0) begin
          m_owner = w;
          m_held  = 0;
          if (w <= 1) m_last_door = w;
        end
      end
    end
  endfunction

  function automatic logic [5:0] e_gnt();
    return (m_owner >= 0) ? 6'(1 << m_owner) : 6'b0;
  endfunction

  function automatic logic [2:0] e_owner();
    return (m_owner >= 0) ? 3'(m_owner) : 3'd7;
  endfunction

  function automatic logic e_busy();
    return (m_owner >= 0) || (m_zero < DEAD);
  endfunction

  // driver: apply req at the falling edge, let one rising edge pass, return at the next falling edge
  task automatic run_cycle(input logic [5:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 6'b0 || owner !== 3'd7 || busy !== 1'b0 || conflict !== 1'b0) begin
      errors++;
      $display("FAIL reset: gnt=%b owner=%0d busy=%b conflict=%b, need 000000/7/0/0",
               gnt, owner, busy, conflict);
    end
    rst_n = 1'b1;
    run_cycle(6'b0);
    checks++;
    if (gnt !== 6'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: gnt=%b busy=%b, need 000000/0", gnt, busy);
    end
  endtask

  task automatic test_hold();
    int on_cnt;
    int dead_cnt;
    on_cnt   = 0;
    dead_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      run_cycle(i == 0 ? 6'b000100 : 6'b0);
      checks++;
      if (gnt !== e_gnt() || owner !== e_owner() || busy !== e_busy()) begin
        errors++;
        $display("FAIL hold[%0d]: gnt=%b owner=%0d busy=%b, need %b/%0d/%b",
                 i, gnt, owner, busy, e_gnt(), e_owner(), e_busy());
      end
      if (gnt == 6'b000100) on_cnt++;
      if (gnt == 6'b0 && busy) dead_cnt++;
    end
    checks++;
    if (on_cnt != HOLD || dead_cnt != DEAD || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_len: grant=%0d dead=%0d busy=%b, need %0d/%0d/0",
               on_cnt, dead_cnt, busy, HOLD, DEAD);
    end
  endtask

  task automatic test_doors();
    logic [5:0] r;
    for (int i = 0; i < 31; i++) begin
      if (i < 10)      r = 6'b000011;
      else if (i < 23) r = 6'b000010;
      else if (i < 24) r = 6'b000001;
      else             r = 6'b000011;
      run_cycle(r);
      checks++;
      if (gnt !== e_gnt() || owner !== e_owner() || busy !== e_busy()) begin
        errors++;
        $display("FAIL doors[%0d]: gnt=%b owner=%0d busy=%b, need %b/%0d/%b",
                 i, gnt, owner, busy, e_gnt(), e_owner(), e_busy());
      end
      if (i == 9 || i == 22 || i == 30) begin
        checks++;
        if (gnt !== (i == 22 ? 6'b000010 : 6'b000001)) begin
          errors++;
          $display("FAIL doors_rr[%0d]: gnt=%b, need %b", i, gnt,
                   (i == 22 ? 6'b000010 : 6'b000001));
        end
      end
    end
    for (int i = 0; i < 16; i++) run_cycle(6'b0);
  endtask

  task automatic test_preempt();
    logic [5:0] r;
    for (int i = 0; i < 10; i++) begin
      if (i < 4)       r = 6'b010000;
      else if (i == 4) r = 6'b011000;
      else             r = 6'b001000;
      run_cycle(r);
      checks++;
      if (gnt !== e_gnt() || owner !== e_owner() || busy !== e_busy()) begin
        errors++;
        $display("FAIL preempt[%0d]: gnt=%b owner=%0d busy=%b, need %b/%0d/%b",
                 i, gnt, owner, busy, e_gnt(), e_owner(), e_busy());
      end
      if (i == 3 || i == 4 || i == 8 || i == 9) begin
        checks++;
        if (gnt !== (i == 3 ? 6'b010000 : (i == 9 ? 6'b001000 : 6'b0))) begin
          errors++;
          $display("FAIL preempt_seq[%0d]: gnt=%b owner=%0d", i, gnt, owner);
        end
      end
    end
    for (int i = 0; i < 16; i++) run_cycle(6'b0);
  endtask

  task automatic test_conflict();
    for (int i = 0; i < 4; i++) begin
      run_cycle(i < 3 ? 6'b110000 : 6'b010000);
      checks++;
      if (conflict !== (i < 3) || gnt !== e_gnt() || busy !== e_busy() ||
          gnt !== (i < 3 ? 6'b0 : 6'b010000)) begin
        errors++;
        $display("FAIL conflict[%0d]: conflict=%b gnt=%b busy=%b, need %b/%b/%b",
                 i, conflict, gnt, busy, (i < 3), e_gnt(), e_busy());
      end
    end
    // thermal owner loses its grant as soon as both thermal requests appear
    run_cycle(6'b110000);
    checks++;
    if (gnt !== 6'b0 || busy !== 1'b1 || gnt !== e_gnt()) begin
      errors++;
      $display("FAIL conflict_kill: gnt=%b busy=%b, need 000000/1", gnt, busy);
    end
    for (int i = 0; i < 8; i++) run_cycle(6'b0);
  endtask

  task automatic test_async_reset();
    run_cycle(6'b000001);
    run_cycle(6'b000001);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (gnt !== 6'b0 || owner !== 3'd7 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: gnt=%b owner=%0d busy=%b, need 000000/7/0",
               gnt, owner, busy);
    end
    req = 6'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_cycle(6'b000011);
      checks++;
      if (gnt !== e_gnt() || owner !== e_owner() || gnt !== 6'b000001) begin
        errors++;
        $display("FAIL post_reset[%0d]: gnt=%b owner=%0d, need 000001/0", i, gnt, owner);
      end
    end
    for (int i = 0; i < 16; i++) run_cycle(6'b0);
  endtask

  task automatic test_random();
    logic [5:0] r;
    logic [5:0] prev_r;
    logic [5:0] prev_gnt;
    int run_len;
    int zero_len;
    r        = 6'b0;
    prev_gnt = gnt;
    run_len  = 0;
    zero_len = 1000;
    for (int i = 0; i < 10000; i++) begin
      prev_r = r;
      if ($urandom_range(0, 2) == 0) r = 6'($urandom) & 6'($urandom);
      run_cycle(r);
      checks++;
      if (gnt !== e_gnt() || owner !== e_owner() || busy !== e_busy() ||
          conflict !== (r[4] & r[5])) begin
        errors++;
        $display("FAIL random[%0d]: req=%b gnt=%b owner=%0d busy=%b, need %b/%0d/%b",
                 i, r, gnt, owner, busy, e_gnt(), e_owner(), e_busy());
      end
      checks++;
      if ($countones(gnt) > 1) begin
        errors++;
        $display("FAIL onehot[%0d]: gnt=%b", i, gnt);
      end
      if (gnt != 6'b0 && prev_gnt == 6'b0) begin
        checks++;
        if (zero_len < DEAD) begin
          errors++;
          $display("FAIL dead_gap[%0d]: gap=%0d, need >= %0d", i, zero_len, DEAD);
        end
        run_len = 0;
      end
      if (gnt == 6'b0 && prev_gnt != 6'b0) begin
        checks++;
        if (run_len < HOLD && !(r[3] || (r[4] && r[5]))) begin
          errors++;
          $display("FAIL min_hold[%0d]: held=%0d, need %0d", i, run_len, HOLD);
        end
        zero_len = 0;
      end
      if (gnt != 6'b0 && prev_gnt != 6'b0 && gnt != prev_gnt) begin
        checks++;
        errors++;
        $display("FAIL direct_switch[%0d]: %b to %b", i, prev_gnt, gnt);
      end
      if (gnt != 6'b0) run_len++;
      else if (zero_len < 1000) zero_len++;
      prev_gnt = gnt;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 6'b0;
    test_reset();
    test_hold();
    test_doors();
    test_preempt();
    test_conflict();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/actuator_arbiter.md
ACTUATOR_ARBITER -- requirements
Module: actuator_arbiter

Interface
REQ-001 Parameter HOLD_CYC, default 8, SHALL set the minimum number of cycles a grant is held.
REQ-002 Parameter DEAD_CYC, default 4, SHALL set the number of idle cycles inserted between any two grants.
REQ-003 Parameter CNT_W, default 4, SHALL set the counter width and SHALL satisfy 2^CNT_W > max(HOLD_CYC, DEAD_CYC).
REQ-004 Clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Rst  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-006 req  input  6  SHALL carry actuator requests: bit0 fdoor, bit1 rdoor, bit2 winbuzz, bit3 alarmbuzz, bit4 heater, bit5 cooler.
REQ-007 gnt  output  6  SHALL be the registered grant vector, same bit order as req, one-hot or all-zero.
REQ-008 owner  output  3  SHALL hold the index (0-5) of the granted bit, or 3'd7 when gnt is zero.
REQ-009 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-010 conflict  output  1  SHALL be high, combinationally, whenever req[4] and req[5] are both high.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, GRANT, DEAD.
REQ-012 Eligible set: req with bits 4 and 5 both masked off when conflict is high; heater and cooler SHALL never be granted while both are requested.
REQ-013 IDLE: if the eligible set is non-empty at edge N, the FSM SHALL enter GRANT, and gnt/owner SHALL show the winner from edge N; latency from request to grant is 1 cycle.
REQ-014 Priority SHALL be: alarmbuzz > doors > winbuzz > heater > cooler.
REQ-015 Doors SHALL be round-robin: when fdoor and rdoor are both eligible and no alarm is eligible, the door not granted most recently SHALL win; after reset fdoor SHALL win the first tie.
REQ-016 The round-robin pointer SHALL update only when a door is granted.
REQ-017 GRANT: the hold counter SHALL start at 0 on entry, increment each cycle, and saturate at HOLD_CYC-1.
REQ-018 GRANT SHALL exit to DEAD when the counter equals HOLD_CYC-1 and req[owner] is low; gnt SHALL drop on that edge.
REQ-019 An owner request that drops before HOLD_CYC cycles SHALL NOT shorten the grant; the grant SHALL last exactly HOLD_CYC cycles.
REQ-020 An owner request that stays high SHALL keep the grant indefinitely unless preempted.
REQ-021 Preemption: if req[3] is high in GRANT and owner != 3, the FSM SHALL enter DEAD on the next edge regardless of the hold count.
REQ-022 If the owner is heater or cooler and conflict rises, the FSM SHALL enter DEAD on the next edge.
REQ-023 DEAD: gnt SHALL be zero and owner 3'd7 for exactly DEAD_CYC cycles, then the FSM SHALL enter IDLE.
REQ-024 Alarm preemption SHALL NOT skip DEAD.
REQ-025 Requests seen during DEAD SHALL be evaluated only in IDLE; no request SHALL be latched.
REQ-026 A request that drops in IDLE before being sampled SHALL produce no grant.
REQ-027 More than one gnt bit SHALL never be high at once.
REQ-028 gnt SHALL never go from one non-zero value to another without at least DEAD_CYC zero cycles between them.

Reset
REQ-029 While Rst is low: state IDLE, gnt=0, owner=3'd7, busy=0, counters=0, round-robin pointer favouring fdoor.
REQ-030 Reset asserted mid-GRANT or mid-DEAD SHALL force gnt to 0 immediately, without waiting for Clk.
REQ-031 After Rst deasserts, the first grant SHALL occur no earlier than the first rising edge after deassertion.

Verification
REQ-032 Bench SHALL cover (HOLD_CYC=8, DEAD_CYC=4):
- req=6'b000100 for 1 cycle in IDLE -> gnt=6'b000100 for exactly 8 cycles, then 4 zero cycles, busy low on the following cycle.
- req=6'b000011 held -> gnt=000001 until req[0] drops; with req[1] still high, next grant after DEAD is 000010; a further tie grants 000001.
- owner=4 (heater) at count 3, req[3] pulsed -> gnt=0 on next edge, 4 DEAD cycles, then gnt=001000.
- req=6'b110000 -> conflict=1, gnt stays 0, busy=0; drop req[5] -> gnt=010000 one cycle later.
- Rst low asynchronously mid-GRANT -> gnt=0 and owner=7 before the next Clk edge; release -> normal arbitration resumes.
- Random req for 10k cycles -> assertions for one-hot gnt, minimum hold, and dead gap never fire.
